// File: rtl/display_scan_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : display_pkg                                                      |
// | Purpose : Shared definitions for the multiplexed seven-segment scanner:    |
// |           FSM state encoding, segment patterns and a small sizing helper.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   // Segment order {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_OFF = 7'h00;

   localparam logic [7:0] AN_OFF  = 8'hFF;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_ctrl_bcd_to_7seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bcd_to_7seg                                                      |
// | Purpose : Combinational BCD to seven-segment decoder. Non-decimal nibbles  |
// |           (A-F) produce a dark digit.                                      |
// | Ports   : bcd_i [3:0] BCD nibble in                                        |
// |           seg_o [6:0] segments {g,f,e,d,c,b,a}, active-high                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_OFF;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_OFF;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : display_scan_ctrl                                                |
// | Purpose : Eight-digit multiplexed seven-segment scanner with dead-time     |
// |           between digits, per-frame shadowing of display data and         |
// |           per-digit blinking.                                              |
// | Ports   : clk, reset (sync, active-high), enable                           |
// |           digits_in[31:0] BCD nibbles, dp_in[7:0], blink_mask[7:0],        |
// |           blink_phase                                                      |
// |           an[7:0] active-low anodes, seg[6:0] {g..a}, dp, scan_idx[2:0],   |
// |           frame_start one-cycle pulse at first SHOW cycle of digit 0       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int unsigned PRESCALE     = 1000,
   parameter int unsigned BLANK_CYCLES = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] digits_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  blink_mask,
   input  logic        blink_phase,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [2:0]  scan_idx,
   output logic        frame_start
);

   localparam int unsigned CNT_MAX = max_u(PRESCALE, BLANK_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [31:0]       sh_digits_q, sh_digits_d;
   logic [7:0]        sh_dp_q, sh_dp_d;
   logic [7:0]        sh_blink_q, sh_blink_d;
   logic [7:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic              fs_q, fs_d;
   logic              load_frame;
   logic [3:0]        dec_bcd;
   logic [6:0]        dec_seg;

   // Outputs are derived from the next-state values so the registered
   // outputs line up with the state they describe, not one cycle behind.
   assign dec_bcd = sh_digits_d[{idx_d, 2'b00} +: 4];

   bcd_to_7seg u_dec (
      .bcd_i (dec_bcd),
      .seg_o (dec_seg)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      load_frame = 1'b0;

      if (!enable) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               idx_d   = 3'd0;
            end
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  state_d    = ST_SHOW;
                  cnt_d      = '0;
                  load_frame = (idx_q == 3'd0);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SHOW: begin
               if (cnt_q == SHOW_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  idx_d   = idx_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = 3'd0;
            end
         endcase
      end

      sh_digits_d = load_frame ? digits_in  : sh_digits_q;
      sh_dp_d     = load_frame ? dp_in      : sh_dp_q;
      sh_blink_d  = load_frame ? blink_mask : sh_blink_q;

      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b0;
      fs_d  = 1'b0;
      if (state_d == ST_SHOW) begin
         // Blinking only darkens the anode; segment data keeps flowing so the
         // digit reappears unchanged when the phase flips.
         if (!(sh_blink_d[idx_d] && blink_phase)) begin
            an_d = ~(8'b0000_0001 << idx_d);
         end
         seg_d = dec_seg;
         dp_d  = sh_dp_d[idx_d];
         fs_d  = load_frame;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         sh_digits_q <= '0;
         sh_dp_q     <= '0;
         sh_blink_q  <= '0;
         an_q        <= AN_OFF;
         seg_q       <= SEG_OFF;
         dp_q        <= 1'b0;
         fs_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         sh_digits_q <= sh_digits_d;
         sh_dp_q     <= sh_dp_d;
         sh_blink_q  <= sh_blink_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         fs_q        <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign scan_idx    = idx_q;
   assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_display_scan_ctrl                                             |
// | Purpose : Directed, table-driven bench for display_scan_ctrl with          |
// |           PRESCALE=4, BLANK_CYCLES=2 (frame = 48 cycles).                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] digits_in;
   logic [7:0]  dp_in;
   logic [7:0]  blink_mask;
   logic        blink_phase;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [2:0]  scan_idx;
   logic        frame_start;

   int tests = 0;
   int fails = 0;
   int k     = 0;   // cycles since reset release

   always #5 clk = ~clk;

   display_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .digits_in   (digits_in),
      .dp_in       (dp_in),
      .blink_mask  (blink_mask),
      .blink_phase (blink_phase),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .scan_idx    (scan_idx),
      .frame_start (frame_start)
   );

   typedef struct {
      int         cyc;
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      logic [2:0] idx;
      logic       fs;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic step_to(input int target);
      while (k < target) step();
   endtask

   task automatic wait_fs();
      int n;
      n = 0;
      step();
      while (!frame_start && n < 100) begin
         step();
         n++;
      end
      chk("wait_frame_start", {31'd0, frame_start}, 32'd1);
   endtask

   task automatic chk_off(input string tag);
      chk({tag, "_an"},  {24'd0, an},       32'hFF);
      chk({tag, "_seg"}, {25'd0, seg},      32'h00);
      chk({tag, "_dp"},  {31'd0, dp},       32'h0);
      chk({tag, "_idx"}, {29'd0, scan_idx}, 32'h0);
      chk({tag, "_fs"},  {31'd0, frame_start}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int vi;
      int fscount;
      logic [6:0] exp_b [8];
      logic [6:0] exp_e [8];

      // cycle, an, seg, dp, idx, fs  (digits 12345678, dp_in 04)
      tbl[0]  = '{1,  8'hFF, 7'h00, 1'b0, 3'd0, 1'b0};
      tbl[1]  = '{2,  8'hFF, 7'h00, 1'b0, 3'd0, 1'b0};
      tbl[2]  = '{3,  8'hFE, 7'h7F, 1'b0, 3'd0, 1'b1};
      tbl[3]  = '{4,  8'hFE, 7'h7F, 1'b0, 3'd0, 1'b0};
      tbl[4]  = '{6,  8'hFE, 7'h7F, 1'b0, 3'd0, 1'b0};
      tbl[5]  = '{7,  8'hFF, 7'h00, 1'b0, 3'd1, 1'b0};
      tbl[6]  = '{9,  8'hFD, 7'h07, 1'b0, 3'd1, 1'b0};
      tbl[7]  = '{15, 8'hFB, 7'h7D, 1'b1, 3'd2, 1'b0};
      tbl[8]  = '{21, 8'hF7, 7'h6D, 1'b0, 3'd3, 1'b0};
      tbl[9]  = '{27, 8'hEF, 7'h66, 1'b0, 3'd4, 1'b0};
      tbl[10] = '{33, 8'hDF, 7'h4F, 1'b0, 3'd5, 1'b0};
      tbl[11] = '{39, 8'hBF, 7'h5B, 1'b0, 3'd6, 1'b0};
      tbl[12] = '{45, 8'h7F, 7'h06, 1'b0, 3'd7, 1'b0};
      tbl[13] = '{49, 8'hFF, 7'h00, 1'b0, 3'd0, 1'b0};
      tbl[14] = '{51, 8'hFE, 7'h7F, 1'b0, 3'd0, 1'b1};

      // digits 3..7 of the old frame after digits_in goes to zero
      exp_b[3] = 7'h6D; exp_b[4] = 7'h66; exp_b[5] = 7'h4F;
      exp_b[6] = 7'h5B; exp_b[7] = 7'h06;
      exp_b[0] = 7'h00; exp_b[1] = 7'h00; exp_b[2] = 7'h00;
      // ABCDEF99: digit0=9, digit1=9, digits 2..7 = F,E,D,C,B,A
      exp_e[0] = 7'h6F; exp_e[1] = 7'h6F;
      exp_e[2] = 7'h00; exp_e[3] = 7'h00; exp_e[4] = 7'h00;
      exp_e[5] = 7'h00; exp_e[6] = 7'h00; exp_e[7] = 7'h00;

      reset       = 1'b1;
      enable      = 1'b1;
      digits_in   = 32'h12345678;
      dp_in       = 8'h04;
      blink_mask  = 8'h00;
      blink_phase = 1'b0;

      // Reset held three cycles with enable high
      for (int i = 0; i < 3; i++) begin
         step();
         chk_off($sformatf("rst%0d", i));
      end
      reset = 1'b0;
      k = 0;

      // Table-driven first frame and start of the second
      vi = 0;
      fscount = 0;
      for (int c = 1; c <= 54; c++) begin
         step();
         if (frame_start) fscount++;
         if (vi < 15 && tbl[vi].cyc == c) begin
            chk($sformatf("v%0d_an", vi),  {24'd0, an},       {24'd0, tbl[vi].an});
            chk($sformatf("v%0d_seg", vi), {25'd0, seg},      {25'd0, tbl[vi].seg});
            chk($sformatf("v%0d_dp", vi),  {31'd0, dp},       {31'd0, tbl[vi].dp});
            chk($sformatf("v%0d_idx", vi), {29'd0, scan_idx}, {29'd0, tbl[vi].idx});
            chk($sformatf("v%0d_fs", vi),  {31'd0, frame_start}, {31'd0, tbl[vi].fs});
            vi++;
         end
      end
      chk("fs_count_54", fscount, 32'd2);

      // Mid-frame data change during digit 3 SHOW of frame 2
      step_to(70);
      chk("midchg_idx", {29'd0, scan_idx}, 32'd3);
      digits_in = 32'h0000_0000;
      for (int d = 3; d < 8; d++) begin
         step_to(52 + 6 * d);
         chk($sformatf("midchg_seg_d%0d", d), {25'd0, seg}, {25'd0, exp_b[d]});
      end
      step_to(99);
      chk("newframe_fs", {31'd0, frame_start}, 32'd1);
      chk("newframe_seg0", {25'd0, seg}, 32'h3F);
      step_to(105);
      chk("newframe_an1", {24'd0, an}, 32'hFD);
      chk("newframe_seg1", {25'd0, seg}, 32'h3F);

      // Blink on digit 0
      blink_mask  = 8'h01;
      blink_phase = 1'b1;
      wait_fs();
      chk("blink_dark_an", {24'd0, an}, 32'hFF);
      chk("blink_dark_idx", {29'd0, scan_idx}, 32'd0);
      for (int i = 0; i < 6; i++) step();
      chk("blink_d1_an", {24'd0, an}, 32'hFD);
      blink_phase = 1'b0;
      wait_fs();
      chk("blink_lit_an", {24'd0, an}, 32'hFE);
      blink_phase = 1'b1;
      step();
      chk("blink_live_an", {24'd0, an}, 32'hFF);
      blink_phase = 1'b0;
      blink_mask  = 8'h00;
      step();
      chk("blink_live_back_an", {24'd0, an}, 32'hFE);

      // Enable dropped in cycle 2 of digit 5 SHOW
      wait_fs();
      for (int i = 0; i < 31; i++) step();
      chk("pre_dis_idx", {29'd0, scan_idx}, 32'd5);
      chk("pre_dis_an", {24'd0, an}, 32'hDF);
      enable = 1'b0;
      step();
      chk_off("dis");
      step();
      step();
      chk("dis_hold_an", {24'd0, an}, 32'hFF);
      enable = 1'b1;
      step();
      chk("reen_b1_an", {24'd0, an}, 32'hFF);
      step();
      chk("reen_b2_an", {24'd0, an}, 32'hFF);
      chk("reen_b2_fs", {31'd0, frame_start}, 32'd0);
      step();
      chk("reen_fs", {31'd0, frame_start}, 32'd1);
      chk("reen_an", {24'd0, an}, 32'hFE);
      chk("reen_idx", {29'd0, scan_idx}, 32'd0);

      // Reset in the middle of SHOW, then non-decimal digits
      digits_in = 32'hABCDEF99;
      wait_fs();
      step();
      reset = 1'b1;
      step();
      chk_off("midrst");
      enable = 1'b0;
      step();
      chk_off("rst_dis");
      enable = 1'b1;
      reset  = 1'b0;
      step();
      step();
      chk("post_rst_b_an", {24'd0, an}, 32'hFF);
      step();
      chk("post_rst_fs", {31'd0, frame_start}, 32'd1);
      chk("post_rst_seg0", {25'd0, seg}, {25'd0, exp_e[0]});
      for (int d = 1; d < 8; d++) begin
         for (int i = 0; i < 6; i++) step();
         chk($sformatf("hex_seg_d%0d", d), {25'd0, seg}, {25'd0, exp_e[d]});
         chk($sformatf("hex_an_d%0d", d), {24'd0, an}, {24'd0, ~(8'b0000_0001 << d)});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
